// File: rtl/sys_bus_pkg.sv
// sys_bus_pkg: bridge FSM states and AXI response codes shared across the sys_bus slice
package sys_bus_pkg;
  typedef enum logic [2:0] {IDLE, WREQ, WWAIT, WRSP, RREQ, RWAIT, RRSP} state_t;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;
endpackage

// File: rtl/sys_bus_if.sv
// sys_bus_if: single-beat system bus with ack/err completion
interface sys_bus_if #(parameter int AW = 32) ();
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          wen;
  logic          ren;
  logic          err;
  logic          ack;
  modport m (output addr, wdata, wen, ren, input rdata, err, ack);
  modport s (input addr, wdata, wen, ren, output rdata, err, ack);
endinterface

// File: rtl/axi4lite_sys_bus_bridge.sv
// axi4lite_sys_bus_bridge: AXI4-Lite slave to sys_bus master, one transaction at a time with ack timeout
module axi4lite_sys_bus_bridge
  import sys_bus_pkg::*;
#(
  parameter int AW  = 32,
  parameter int TMO = 255
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [AW-1:0] awaddr_i,
  input  logic          awvalid_i,
  output logic          awready_o,
  input  logic [31:0]   wdata_i,
  input  logic [3:0]    wstrb_i,
  input  logic          wvalid_i,
  output logic          wready_o,
  output logic [1:0]    bresp_o,
  output logic          bvalid_o,
  input  logic          bready_i,
  input  logic [AW-1:0] araddr_i,
  input  logic          arvalid_i,
  output logic          arready_o,
  output logic [31:0]   rdata_o,
  output logic [1:0]    rresp_o,
  output logic          rvalid_o,
  input  logic          rready_i,
  sys_bus_if.m          bus
);
  state_t        state, state_nx;
  logic [15:0]   cnt;
  logic          prefer_w;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic          wr_go, rd_go, in_req, is_rd, tmo_hit, done;
  logic [1:0]    done_resp;
  assign wr_go     = state == IDLE && awvalid_i && wvalid_i && (prefer_w || !arvalid_i);
  assign rd_go     = state == IDLE && arvalid_i && !wr_go;
  assign in_req    = state inside {WREQ, WWAIT, RREQ, RWAIT};
  assign is_rd     = state inside {RREQ, RWAIT};
  assign tmo_hit   = cnt + 16'd1 == 16'(TMO);
  assign done      = in_req && (bus.ack || tmo_hit);
  // ack wins over a timeout landing in the same cycle
  assign done_resp = bus.ack ? (bus.err ? SLVERR : OKAY) : DECERR;
  assign awready_o = wr_go;
  assign wready_o  = wr_go;
  assign arready_o = rd_go;
  assign bvalid_o  = state == WRSP;
  assign rvalid_o  = state == RRSP;
  assign bus.wen   = state == WREQ;
  assign bus.ren   = state == RREQ;
  assign bus.addr  = addr_q;
  assign bus.wdata = wdata_q;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:         state_nx = wr_go ? (wstrb_i == 4'hF ? WREQ : WRSP) : rd_go ? RREQ : IDLE;
      WREQ, WWAIT:  state_nx = done ? WRSP : WWAIT;
      RREQ, RWAIT:  state_nx = done ? RRSP : RWAIT;
      WRSP:         state_nx = bready_i ? IDLE : WRSP;
      RRSP:         state_nx = rready_i ? IDLE : RRSP;
      default:      state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      cnt      <= '0;
      prefer_w <= 1'b1;
      addr_q   <= '0;
      wdata_q  <= '0;
      bresp_o  <= '0;
      rresp_o  <= '0;
      rdata_o  <= '0;
    end else begin
      state <= state_nx;
      if (in_req) cnt <= cnt + 16'd1;
      if (wr_go || rd_go) begin
        cnt      <= '0;
        prefer_w <= rd_go;
        addr_q   <= wr_go ? awaddr_i : araddr_i;
      end
      if (wr_go) wdata_q <= wdata_i;
      if (wr_go && wstrb_i != 4'hF) bresp_o <= SLVERR;
      if (done && is_rd) begin
        rresp_o <= done_resp;
        rdata_o <= bus.ack ? bus.rdata : 32'd0;
      end
      if (done && !is_rd) bresp_o <= done_resp;
    end
  end
endmodule
